// File: rtl/fwd_pkg.sv
// Shared tag type, bubble constant and parameter bounds for the forwarding/hazard unit.
// No logic or latency of its own; stall and backpressure behaviour live in the users.
package fwd_pkg;

  localparam int REG_AW_MAX         = 6;
  localparam int NUM_FWD_STAGES_MIN = 2;
  localparam int NUM_FWD_STAGES_MAX = 4;
  localparam int MC_LAT_MIN         = 1;
  localparam int MC_LAT_MAX         = 16;
  localparam int FWD_SRC_RF         = 0;

  typedef logic [REG_AW_MAX-1:0] reg_t;

  typedef struct packed {
    logic valid;
    reg_t rd;
    reg_t rs1;
    reg_t rs2;
    logic use_rs1;
    logic use_rs2;
    logic rw;
    logic is_load;
    logic is_mc;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '0;

  // A tag can only ever produce a forwardable result if it writes a non-x0 register.
  function automatic logic tag_writes(tag_t t);
    return t.valid & t.rw & (t.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_enc.sv
// Priority comparator: youngest post-EX stage whose destination feeds one EX operand.
// Latency: 0 (pure combinational); no backpressure.
module fwd_sel_enc
  import fwd_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2,
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  tag_t [NUM_FWD_STAGES:1] stages,
  input  reg_t                    rs,
  input  logic                    use_rs,
  output logic [SEL_W-1:0]        sel
);

  // Walk oldest to youngest so the youngest match is the last write and wins.
  // Load data is not available until stage 2, so a load at stage 1 never forwards.
  always_comb begin
    sel = SEL_W'(FWD_SRC_RF);
    for (int s = NUM_FWD_STAGES; s >= 1; s--) begin
      if (use_rs && tag_writes(stages[s]) && (stages[s].rd == rs) &&
          (!stages[s].is_load || (s >= 2))) begin
        sel = SEL_W'(s);
      end
    end
  end

  // Source fields of the producer tags are irrelevant to forwarding.
  logic unused_tag_bits;
  always_comb begin
    unused_tag_bits = 1'b0;
    for (int s = 1; s <= NUM_FWD_STAGES; s++) begin
      unused_tag_bits = unused_tag_bits ^ (^{stages[s].rs1, stages[s].rs2,
                                             stages[s].use_rs1, stages[s].use_rs2,
                                             stages[s].is_mc});
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Shadow pipeline of in-flight tags driving EX forward selects and decode stalls (load-use, mul/div).
// Latency: selects are combinational from registered tags; stall_o holds decode, hold_i freezes all state.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int NUM_FWD_STAGES = 2,
  parameter int MC_LAT         = 4,
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rw,
  input  logic              id_is_load,
  input  logic              id_is_mc,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic [SEL_W-1:0]  fwd_rs1,
  output logic [SEL_W-1:0]  fwd_rs2,
  output logic              stall_o,
  output logic              mc_busy_o
);

  localparam int              MC_W    = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LAT - 1);

  if (NUM_FWD_STAGES < NUM_FWD_STAGES_MIN || NUM_FWD_STAGES > NUM_FWD_STAGES_MAX) begin : g_bad_stages
    $error("fwd_hazard_unit: NUM_FWD_STAGES out of range");
  end
  if (MC_LAT < MC_LAT_MIN || MC_LAT > MC_LAT_MAX) begin : g_bad_mc_lat
    $error("fwd_hazard_unit: MC_LAT out of range");
  end
  if (REG_AW > REG_AW_MAX) begin : g_bad_reg_aw
    $error("fwd_hazard_unit: REG_AW wider than tag register field");
  end

  tag_t [NUM_FWD_STAGES:0] stg_q, stg_d;
  logic [MC_W-1:0]         mc_cnt_q, mc_cnt_d;
  tag_t                    id_tag;
  logic                    load_use;

  always_comb begin
    id_tag         = TAG_BUBBLE;
    id_tag.valid   = 1'b1;
    id_tag.rd      = reg_t'(id_rd);
    id_tag.rs1     = reg_t'(id_rs1);
    id_tag.rs2     = reg_t'(id_rs2);
    id_tag.use_rs1 = id_use_rs1;
    id_tag.use_rs2 = id_use_rs2;
    id_tag.rw      = id_rw;
    id_tag.is_load = id_is_load;
    id_tag.is_mc   = id_is_mc;
  end

  assign load_use = id_valid & tag_writes(stg_q[0]) & stg_q[0].is_load &
                    ((id_use_rs1 & (id_tag.rs1 == stg_q[0].rd)) |
                     (id_use_rs2 & (id_tag.rs2 == stg_q[0].rd)));

  assign mc_busy_o = (mc_cnt_q != '0);
  assign stall_o   = mc_busy_o | (load_use & ~flush_i);

  // Busy counter outranks flush: a flush during a mul/div is not expected, and is ignored.
  always_comb begin
    stg_d    = stg_q;
    mc_cnt_d = mc_cnt_q;
    if (!hold_i) begin
      for (int s = 2; s <= NUM_FWD_STAGES; s++) begin
        stg_d[s] = stg_q[s-1];
      end
      if (mc_busy_o) begin
        mc_cnt_d = mc_cnt_q - MC_W'(1);
        stg_d[1] = TAG_BUBBLE;
      end else begin
        stg_d[1] = stg_q[0];
        if (flush_i || load_use || !id_valid) begin
          stg_d[0] = TAG_BUBBLE;
        end else begin
          stg_d[0] = id_tag;
          if (id_is_mc) begin
            mc_cnt_d = MC_LOAD;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q    <= '0;
      mc_cnt_q <= '0;
    end else begin
      stg_q    <= stg_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  fwd_sel_enc #(
    .NUM_FWD_STAGES (NUM_FWD_STAGES),
    .SEL_W          (SEL_W)
  ) u_sel_rs1 (
    .stages (stg_q[NUM_FWD_STAGES:1]),
    .rs     (stg_q[0].rs1),
    .use_rs (stg_q[0].valid & stg_q[0].use_rs1),
    .sel    (fwd_rs1)
  );

  fwd_sel_enc #(
    .NUM_FWD_STAGES (NUM_FWD_STAGES),
    .SEL_W          (SEL_W)
  ) u_sel_rs2 (
    .stages (stg_q[NUM_FWD_STAGES:1]),
    .rs     (stg_q[0].rs2),
    .use_rs (stg_q[0].valid & stg_q[0].use_rs2),
    .sel    (fwd_rs2)
  );

  // The multi-cycle flag is only acted on at issue, from the decode inputs.
  logic unused_tag_bits;
  assign unused_tag_bits = stg_q[0].is_mc;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: per-cycle expected outputs queued at drive, checked at negedge.
module tb_fwd_hazard_unit;

  typedef struct packed {
    logic [1:0] f1;
    logic [1:0] f2;
    logic       stall;
    logic       busy;
  } out_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       rw;
    logic       ld;
    logic       mc;
    logic       flush;
    logic       hold;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_use_rs1, id_use_rs2, id_rw, id_is_load, id_is_mc;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       flush_i, hold_i;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic       stall_o, mc_busy_o;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];

  fwd_hazard_unit #(
    .REG_AW         (5),
    .NUM_FWD_STAGES (2),
    .MC_LAT         (4),
    .SEL_W          (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_rw      (id_rw),
    .id_is_load (id_is_load),
    .id_is_mc   (id_is_mc),
    .flush_i    (flush_i),
    .hold_i     (hold_i),
    .fwd_rs1    (fwd_rs1),
    .fwd_rs2    (fwd_rs2),
    .stall_o    (stall_o),
    .mc_busy_o  (mc_busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && flush_i && mc_busy_o) begin
      $display("FAIL illegal_flush flush_i=1 while mc_busy_o=1 at %0t", $time);
      errors++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic stim_t ins(bit v, int rd, int rs1, int rs2, bit u1, bit u2,
                                bit rw, bit ld, bit mc);
    stim_t s;
    s       = '0;
    s.vld   = v;
    s.rd    = 5'(rd);
    s.rs1   = 5'(rs1);
    s.rs2   = 5'(rs2);
    s.u1    = u1;
    s.u2    = u2;
    s.rw    = rw;
    s.ld    = ld;
    s.mc    = mc;
    return s;
  endfunction

  function automatic out_t o(int f1, int f2, bit st, bit bz);
    out_t r;
    r.f1    = 2'(f1);
    r.f2    = 2'(f2);
    r.stall = st;
    r.busy  = bz;
    return r;
  endfunction

  task automatic apply(input stim_t s);
    id_valid   = s.vld;
    id_rd      = s.rd;
    id_rs1     = s.rs1;
    id_rs2     = s.rs2;
    id_use_rs1 = s.u1;
    id_use_rs2 = s.u2;
    id_rw      = s.rw;
    id_is_load = s.ld;
    id_is_mc   = s.mc;
    flush_i    = s.flush;
    hold_i     = s.hold;
  endtask

  task automatic idle(input int n);
    apply('0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t got, want;
    apply('0);
    rst_n = 1'b0;
    #12;
    exp_q.push_back(o(0, 0, 0, 0));
    got  = {fwd_rs1, fwd_rs2, stall_o, mc_busy_o};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      $display("FAIL reset_hold got %b want %b", got, want);
      errors++;
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(o(0, 0, 0, 0));
    @(negedge clk);
    got  = {fwd_rs1, fwd_rs2, stall_o, mc_busy_o};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      $display("FAIL reset_release got %b want %b", got, want);
      errors++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_forward();
    stim_t s[$];
    out_t  e[$];
    out_t  got, want;
    s.push_back(ins(1, 5, 1, 2, 1, 1, 1, 0, 0)); e.push_back(o(0, 0, 0, 0));
    s.push_back(ins(1, 6, 5, 1, 1, 1, 1, 0, 0)); e.push_back(o(0, 0, 0, 0));
    s.push_back(ins(1, 7, 1, 5, 1, 1, 1, 0, 0)); e.push_back(o(1, 0, 0, 0));
    s.push_back(ins(1, 0, 1, 2, 1, 1, 1, 0, 0)); e.push_back(o(0, 2, 0, 0));
    s.push_back(ins(1, 9, 0, 0, 1, 1, 1, 0, 0)); e.push_back(o(0, 0, 0, 0));
    s.push_back('0);                             e.push_back(o(0, 0, 0, 0));
    s.push_back('0);                             e.push_back(o(0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = {fwd_rs1, fwd_rs2, stall_o, mc_busy_o};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        $display("FAIL forward cycle %0d got %b want %b", i, got, want);
        errors++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s[$];
    out_t  e[$];
    out_t  got, want;
    s.push_back(ins(1, 7, 2, 0, 1, 0, 1, 1, 0)); e.push_back(o(0, 0, 0, 0));
    s.push_back(ins(1, 8, 7, 7, 1, 1, 1, 0, 0)); e.push_back(o(0, 0, 1, 0));
    s.push_back(ins(1, 8, 7, 7, 1, 1, 1, 0, 0)); e.push_back(o(0, 0, 0, 0));
    s.push_back('0);                             e.push_back(o(2, 2, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = {fwd_rs1, fwd_rs2, stall_o, mc_busy_o};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        $display("FAIL load_use cycle %0d got %b want %b", i, got, want);
        errors++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_multicycle();
    stim_t s[$];
    out_t  e[$];
    out_t  got, want;
    s.push_back(ins(1, 9, 1, 2, 1, 1, 1, 0, 1));  e.push_back(o(0, 0, 0, 0));
    repeat (3) begin
      s.push_back(ins(1, 10, 9, 0, 1, 0, 1, 0, 0)); e.push_back(o(0, 0, 1, 1));
    end
    s.push_back(ins(1, 10, 9, 0, 1, 0, 1, 0, 0)); e.push_back(o(0, 0, 0, 0));
    s.push_back('0);                              e.push_back(o(1, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = {fwd_rs1, fwd_rs2, stall_o, mc_busy_o};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        $display("FAIL multicycle cycle %0d got %b want %b", i, got, want);
        errors++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_youngest();
    stim_t s[$];
    out_t  e[$];
    out_t  got, want;
    s.push_back(ins(1, 3, 1, 2, 1, 1, 1, 0, 0)); e.push_back(o(0, 0, 0, 0));
    s.push_back(ins(1, 3, 2, 1, 1, 1, 1, 0, 0)); e.push_back(o(0, 0, 0, 0));
    s.push_back(ins(1, 4, 3, 3, 1, 0, 1, 0, 0)); e.push_back(o(0, 0, 0, 0));
    s.push_back('0);                             e.push_back(o(1, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = {fwd_rs1, fwd_rs2, stall_o, mc_busy_o};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        $display("FAIL youngest cycle %0d got %b want %b", i, got, want);
        errors++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flush_hold();
    stim_t s[$];
    out_t  e[$];
    stim_t t;
    out_t  got, want;
    s.push_back(ins(1, 7, 2, 0, 1, 0, 1, 1, 0));  e.push_back(o(0, 0, 0, 0));
    t = ins(1, 8, 7, 7, 1, 1, 1, 0, 0); t.flush = 1'b1;
    s.push_back(t);                               e.push_back(o(0, 0, 0, 0));
    s.push_back(ins(1, 11, 8, 0, 1, 0, 1, 0, 0)); e.push_back(o(0, 0, 0, 0));
    s.push_back('0);                              e.push_back(o(0, 0, 0, 0));
    s.push_back(ins(1, 9, 1, 2, 1, 1, 1, 0, 1));  e.push_back(o(0, 0, 0, 0));
    s.push_back(ins(1, 10, 9, 0, 1, 0, 1, 0, 0)); e.push_back(o(0, 0, 1, 1));
    t = ins(1, 10, 9, 0, 1, 0, 1, 0, 0); t.hold = 1'b1;
    repeat (5) begin
      s.push_back(t);                             e.push_back(o(0, 0, 1, 1));
    end
    repeat (2) begin
      s.push_back(ins(1, 10, 9, 0, 1, 0, 1, 0, 0)); e.push_back(o(0, 0, 1, 1));
    end
    s.push_back(ins(1, 10, 9, 0, 1, 0, 1, 0, 0)); e.push_back(o(0, 0, 0, 0));
    t = '0; t.hold = 1'b1;
    repeat (2) begin
      s.push_back(t);                             e.push_back(o(1, 0, 0, 0));
    end
    s.push_back('0);                              e.push_back(o(1, 0, 0, 0));
    s.push_back('0);                              e.push_back(o(0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = {fwd_rs1, fwd_rs2, stall_o, mc_busy_o};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        $display("FAIL flush_hold cycle %0d got %b want %b", i, got, want);
        errors++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t s[$];
    out_t  e[$];
    out_t  got, want;
    s.push_back(ins(1, 9, 1, 2, 1, 1, 1, 0, 1));  e.push_back(o(0, 0, 0, 0));
    s.push_back(ins(1, 10, 9, 0, 1, 0, 1, 0, 0)); e.push_back(o(0, 0, 1, 1));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = {fwd_rs1, fwd_rs2, stall_o, mc_busy_o};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        $display("FAIL reset_mid pre cycle %0d got %b want %b", i, got, want);
        errors++;
      end
      @(posedge clk);
      #1;
    end
    apply('0);
    #1 rst_n = 1'b0;
    #1;
    exp_q.push_back(o(0, 0, 0, 0));
    got  = {fwd_rs1, fwd_rs2, stall_o, mc_busy_o};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      $display("FAIL reset_mid async got %b want %b", got, want);
      errors++;
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    s.delete();
    e.delete();
    s.push_back(ins(1, 12, 1, 2, 1, 1, 1, 0, 0));  e.push_back(o(0, 0, 0, 0));
    s.push_back(ins(1, 13, 12, 0, 1, 0, 1, 0, 0)); e.push_back(o(0, 0, 0, 0));
    s.push_back('0);                               e.push_back(o(1, 0, 0, 0));
    s.push_back('0);                               e.push_back(o(0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = {fwd_rs1, fwd_rs2, stall_o, mc_busy_o};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        $display("FAIL reset_mid post cycle %0d got %b want %b", i, got, want);
        errors++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    apply('0);
    test_reset();
    test_forward();
    idle(3);
    test_load_use();
    idle(3);
    test_multicycle();
    idle(3);
    test_youngest();
    idle(3);
    test_flush_hold();
    idle(3);
    test_reset_mid_stall();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined RISC-V integer core. It tracks the destination and source tags of every in-flight instruction in its own shadow pipeline, from EX through NUM_FWD_STAGES later stages. From that state it generates registered-state-based forwarding selects for the EX operands and decode-side stall requests. Stalls cover load-use hazards and multi-cycle (mul/div) EX occupancy; it also handles branch flush and external pipeline hold.

## Interface
Parameters:
- REG_AW, 5: register address width.
- NUM_FWD_STAGES, 2: forwardable stages after EX (1 = EX/MEM, 2 = MEM/WB, …); legal range 2..4.
- MC_LAT, 4: EX occupancy in cycles of a multi-cycle op; legal range 1..16.
- SEL_W, $clog2(NUM_FWD_STAGES+1): forward select width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  decode source registers.
- id_use_rs1, id_use_rs2  in  1  source actually read.
- id_rd  in  REG_AW  decode destination.
- id_rw  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_is_mc  in  1  instruction is a multi-cycle op.
- flush_i  in  1  taken branch in EX; kill decode slot.
- hold_i  in  1  external freeze (memory wait).
- fwd_rs1, fwd_rs2  out  SEL_W  0 = register file, k = stage k result.
- stall_o  out  1  hold fetch/decode this cycle.
- mc_busy_o  out  1  multi-cycle op occupying EX.

## Operation
- Tag per stage s (0 = EX, 1..NUM_FWD_STAGES): valid, rd, rs1, rs2, use_rs1, use_rs2, rw, is_load, is_mc.
- Stage s is a source for operand r when:
  - valid & rw & rd≠0 & rd==rs_r & use_r.
  - A load is a source only at s≥2.
- fwd_rsX is the lowest matching s (youngest wins), else 0. It is computed combinationally from registered tags only.
- load_use = stage0 valid & is_load & rw & rd≠0 & ((id_use_rs1 & id_rs1==rd) | (id_use_rs2 & id_rs2==rd)) & id_valid.
- mc_busy_o = (mc_cnt≠0).
- stall_o = mc_busy_o | (load_use & ~flush_i).
- Per-cycle update; the first matching rule applies:
  1. hold_i: all tags and mc_cnt frozen.
  2. mc_cnt≠0: mc_cnt−1; stage0 holds; stage1 gets a bubble; stages ≥2 shift.
  3. flush_i: stage0 gets a bubble; stages ≥1 shift.
  4. load_use: stage0 gets a bubble; stages ≥1 shift.
  5. Otherwise: stage0 gets the ID tag if id_valid, else a bubble; stages ≥1 shift.
- In rule 5, when a valid id_is_mc tag enters stage0, mc_cnt loads MC_LAT−1. MC_LAT=1 never busies.
- Bubble = all-zero tag. Tags shifted out of the last stage are dropped.
- flush_i while mc_busy_o is illegal; the bench asserts it never occurs, and the RTL ignores it (rule 2 wins).

## Timing
- Reset (async assert, sync release):
  - all tags zero, mc_cnt=0.
  - fwd_rs1=fwd_rs2=0, stall_o=0, mc_busy_o=0.
- Forward selects are valid in the same cycle the consumer sits in EX (zero latency from tag state).
- Load-use costs exactly 1 bubble.
- A multi-cycle op stalls exactly MC_LAT−1 cycles, excluding hold cycles.
- hold_i does not assert stall_o. Outputs stay stable during hold because the tags are frozen.
- Reset mid-stall clears mc_cnt immediately and deasserts stall_o.

## Structure
- Package fwd_pkg holds:
  - the stage tag typedef and bubble constant.
  - FWD_SRC_RF=0.
  - legal parameter bounds.
- Sub-module fwd_sel_enc is the priority comparator over stages, returning SEL_W. It is instantiated once per operand.
- mc_cnt width is $clog2(MC_LAT).

## Test plan
- add x5 issued, then dependent add x6,x5,x1: next cycle fwd_rs1=1; one cycle later a dependent in EX gets fwd_rs1=2; rd=x0 always yields 0.
- lw x7 in EX while decode has add x8,x7,x7: stall_o=1 for 1 cycle, stage0 bubble; consumer then sees fwd_rs1=fwd_rs2=2.
- MC_LAT=4, mul x9 issued: mc_busy_o and stall_o are high 3 cycles, stage1 gets bubbles; the dependent then gets fwd_rs1=1.
- x3 is in both stage1 and stage2 with different producers: fwd=1 (youngest wins).
- flush_i together with load_use: stall_o=0, stage0 bubble. hold_i for 5 cycles during an mc op: mc_cnt frozen, total stall is still 3 unheld cycles.
- rst_n pulsed low with mc_cnt=2: all outputs 0 asynchronously, and after release the first issued instruction proceeds with no stall.
